// File: rtl/camera_tx_pkg.sv
// Shared types and constants for the camera test-pattern transmitter.
// Holds the FSM encoding, pattern codes, datapath widths and the pixel generator.
package camera_tx_pkg;

  localparam int unsigned PIX_W  = 12;
  localparam int unsigned XY_W   = 12;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned FCNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_LINE,
    ST_HBLANK,
    ST_TRAIL,
    ST_VBLANK
  } state_e;

  localparam logic [1:0] PAT_HRAMP = 2'd0;
  localparam logic [1:0] PAT_VRAMP = 2'd1;
  localparam logic [1:0] PAT_CHECK = 2'd2;
  localparam logic [1:0] PAT_FRAME = 2'd3;

  function automatic logic [PIX_W-1:0] pattern_pix(input logic [1:0]      sel,
                                                   input logic [XY_W-1:0] x,
                                                   input logic [XY_W-1:0] y,
                                                   input logic [3:0]      fc);
    logic [PIX_W-1:0] pix;
    case (sel)
      PAT_HRAMP: pix = x;
      PAT_VRAMP: pix = y;
      PAT_CHECK: pix = {PIX_W{x[0] ^ y[0]}};
      default:   pix = {fc, 8'h5A};
    endcase
    return pix;
  endfunction

endpackage

// File: rtl/camera_tx_if.sv
// Timing bus between the frame/line sequencer and the pixel generator.
interface camera_tx_if;
  import camera_tx_pkg::*;

  logic            fval;
  logic            lval;
  logic            frame_done;
  logic            busy;
  logic            active;
  logic            frame_start;
  logic            frame_end;
  logic [XY_W-1:0] x;
  logic [XY_W-1:0] y;

  modport master (output fval, lval, frame_done, busy, active, frame_start, frame_end, x, y);
  modport slave  (input  fval, lval, frame_done, busy, active, frame_start, frame_end, x, y);
endinterface

// File: rtl/camera_tx_timing.sv
// Frame/line sequencer: owns the FSM and x/y/phase counters.
// Registered outputs trail the state by one cycle; active/frame_start/frame_end are same-cycle strobes.
module camera_tx_timing import camera_tx_pkg::*; #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned H_BLANK  = 32,
  parameter int unsigned V_BLANK  = 16,
  parameter int unsigned FV_LEAD  = 4,
  parameter int unsigned FV_TRAIL = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         enable,
  camera_tx_if.master  tim
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  phase_q, phase_d;
  logic [XY_W-1:0]   x_q, x_d;
  logic [XY_W-1:0]   y_q, y_d;
  logic              fval_q, lval_q, frame_done_q, busy_q;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    x_d     = x_q;
    y_d     = y_q;
    case (state_q)
      ST_IDLE: begin
        phase_d = '0;
        if (enable) state_d = ST_LEAD;
      end
      ST_LEAD: begin
        if (phase_q == CNT_W'(FV_LEAD - 1)) begin
          state_d = ST_LINE;
          phase_d = '0;
          x_d     = '0;
          y_d     = '0;
        end else begin
          phase_d = phase_q + CNT_W'(1);
        end
      end
      ST_LINE: begin
        if (x_q == XY_W'(H_ACTIVE - 1)) begin
          state_d = (y_q == XY_W'(V_ACTIVE - 1)) ? ST_TRAIL : ST_HBLANK;
          phase_d = '0;
        end else begin
          x_d = x_q + XY_W'(1);
        end
      end
      ST_HBLANK: begin
        if (phase_q == CNT_W'(H_BLANK - 1)) begin
          state_d = ST_LINE;
          phase_d = '0;
          x_d     = '0;
          y_d     = y_q + XY_W'(1);
        end else begin
          phase_d = phase_q + CNT_W'(1);
        end
      end
      ST_TRAIL: begin
        if (phase_q == CNT_W'(FV_TRAIL - 1)) begin
          state_d = ST_VBLANK;
          phase_d = '0;
        end else begin
          phase_d = phase_q + CNT_W'(1);
        end
      end
      ST_VBLANK: begin
        if (phase_q == CNT_W'(V_BLANK - 1)) begin
          state_d = enable ? ST_LEAD : ST_IDLE;
          phase_d = '0;
        end else begin
          phase_d = phase_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        phase_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      phase_q      <= '0;
      x_q          <= '0;
      y_q          <= '0;
      fval_q       <= 1'b0;
      lval_q       <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      x_q          <= x_d;
      y_q          <= y_d;
      fval_q       <= state_q inside {ST_LEAD, ST_LINE, ST_HBLANK, ST_TRAIL};
      lval_q       <= (state_q == ST_LINE);
      frame_done_q <= tim.frame_end;
      busy_q       <= (state_q != ST_IDLE);
    end
  end

  assign tim.fval        = fval_q;
  assign tim.lval        = lval_q;
  assign tim.frame_done  = frame_done_q;
  assign tim.busy        = busy_q;
  assign tim.active      = (state_q == ST_LINE);
  assign tim.frame_start = (state_d == ST_LEAD) && (state_q != ST_LEAD);
  // First VBLANK cycle: the registered outputs show fval falling on the next cycle.
  assign tim.frame_end   = (state_q == ST_VBLANK) && (phase_q == '0);
  assign tim.x           = x_q;
  assign tim.y           = y_q;

endmodule

// File: rtl/camera_pattern_tx.sv
// Camera-style test pattern transmitter: timing from camera_tx_timing,
// pattern latching, pixel generation and completed-frame counting here.
module camera_pattern_tx import camera_tx_pkg::*; #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned H_BLANK  = 32,
  parameter int unsigned V_BLANK  = 16,
  parameter int unsigned FV_LEAD  = 4,
  parameter int unsigned FV_TRAIL = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [1:0]        pattern_sel,
  output logic [PIX_W-1:0]  pix_d,
  output logic              fval,
  output logic              lval,
  output logic              frame_done,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              busy
);

  camera_tx_if tim_if ();

  camera_tx_timing #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .H_BLANK  (H_BLANK),
    .V_BLANK  (V_BLANK),
    .FV_LEAD  (FV_LEAD),
    .FV_TRAIL (FV_TRAIL)
  ) u_timing (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .tim     (tim_if)
  );

  logic [1:0]        pat_q;
  logic [PIX_W-1:0]  pix_q, pix_d_next;
  logic [FCNT_W-1:0] frame_cnt_q;

  always_comb begin
    pix_d_next = '0;
    if (tim_if.active)
      pix_d_next = pattern_pix(pat_q, tim_if.x, tim_if.y, frame_cnt_q[3:0]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pat_q       <= PAT_HRAMP;
      pix_q       <= '0;
      frame_cnt_q <= '0;
    end else begin
      if (tim_if.frame_start)
        pat_q <= pattern_sel;
      pix_q <= pix_d_next;
      if (tim_if.frame_end)
        frame_cnt_q <= frame_cnt_q + FCNT_W'(1);
    end
  end

  assign pix_d      = pix_q;
  assign fval       = tim_if.fval;
  assign lval       = tim_if.lval;
  assign frame_done = tim_if.frame_done;
  assign frame_cnt  = frame_cnt_q;
  assign busy       = tim_if.busy;

endmodule

// File: tb/tb_camera_pattern_tx.sv
// Scoreboard bench for camera_pattern_tx with a 4x3 frame (23-cycle period).
module tb_camera_pattern_tx;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic [11:0] pix_d;
  logic        fval, lval, frame_done, busy;
  logic [15:0] frame_cnt;

  int checks = 0;
  int errors = 0;
  bit mon_on = 1'b0;

  logic [11:0] exp_pix[$];
  logic [15:0] exp_fcnt[$];

  camera_tx_if mon_if ();
  assign mon_if.fval        = fval;
  assign mon_if.lval        = lval;
  assign mon_if.frame_done  = frame_done;
  assign mon_if.busy        = busy;
  assign mon_if.active      = 1'b0;
  assign mon_if.frame_start = 1'b0;
  assign mon_if.frame_end   = 1'b0;
  assign mon_if.x           = '0;
  assign mon_if.y           = '0;

  camera_pattern_tx #(
    .H_ACTIVE (4),
    .V_ACTIVE (3),
    .H_BLANK  (2),
    .V_BLANK  (3),
    .FV_LEAD  (2),
    .FV_TRAIL (2)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .pattern_sel (pattern_sel),
    .pix_d       (pix_d),
    .fval        (fval),
    .lval        (lval),
    .frame_done  (frame_done),
    .frame_cnt   (frame_cnt),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_line(input logic [11:0] a, input logic [11:0] b,
                           input logic [11:0] c, input logic [11:0] d);
    exp_pix.push_back(a);
    exp_pix.push_back(b);
    exp_pix.push_back(c);
    exp_pix.push_back(d);
  endtask

  task automatic push_hramp_frame();
    push_line(12'h000, 12'h001, 12'h002, 12'h003);
    push_line(12'h000, 12'h001, 12'h002, 12'h003);
    push_line(12'h000, 12'h001, 12'h002, 12'h003);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // Monitor: pops expected pixels on every lval cycle and frame counts on every frame_done.
  always @(negedge clk) begin
    if (mon_on) begin
      if (mon_if.lval) begin
        if (exp_pix.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pix_unexpected: actual %0h required none (t=%0t)", pix_d, $time);
        end else begin
          check("pix", {20'd0, pix_d}, {20'd0, exp_pix.pop_front()});
        end
      end else begin
        check("pix_blank", {20'd0, pix_d}, 32'd0);
      end
      if (mon_if.frame_done) begin
        if (exp_fcnt.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL frame_done_unexpected: actual cnt %0h required no pulse (t=%0t)", frame_cnt, $time);
        end else begin
          check("frame_cnt", {16'd0, frame_cnt}, {16'd0, exp_fcnt.pop_front()});
        end
      end
    end
  end

  initial begin
    int m;
    logic exp_f, exp_l;

    #2 reset_n = 1'b0;
    #1;
    check("rst_pix",   {20'd0, pix_d}, 32'd0);
    check("rst_fval",  {31'd0, fval}, 32'd0);
    check("rst_lval",  {31'd0, lval}, 32'd0);
    check("rst_fdone", {31'd0, frame_done}, 32'd0);
    check("rst_fcnt",  {16'd0, frame_cnt}, 32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    mon_on = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_fval", {31'd0, fval}, 32'd0);

    // Free-running timing, two frames of horizontal ramp
    pattern_sel = 2'd0;
    push_hramp_frame();
    push_hramp_frame();
    exp_fcnt.push_back(16'd1);
    exp_fcnt.push_back(16'd2);
    enable = 1'b1;
    for (int k = 0; k < 46; k++) begin
      @(negedge clk);
      if (k == 0) begin
        check("fval_first", {31'd0, fval}, 32'd0);
      end else begin
        m = (k - 1) % 23;
        exp_f = (m < 20);
        exp_l = (m >= 2 && m <= 5) || (m >= 8 && m <= 11) || (m >= 14 && m <= 17);
        check("fval_seq", {31'd0, fval}, {31'd0, exp_f});
        check("lval_seq", {31'd0, lval}, {31'd0, exp_l});
      end
      if (k == 45) enable = 1'b0;
    end
    wait_idle("free_run");

    // Pattern latching: change select mid-frame
    pattern_sel = 2'd1;
    push_line(12'h000, 12'h000, 12'h000, 12'h000);
    push_line(12'h001, 12'h001, 12'h001, 12'h001);
    push_line(12'h002, 12'h002, 12'h002, 12'h002);
    push_line(12'h000, 12'hFFF, 12'h000, 12'hFFF);
    push_line(12'hFFF, 12'h000, 12'hFFF, 12'h000);
    push_line(12'h000, 12'hFFF, 12'h000, 12'hFFF);
    exp_fcnt.push_back(16'd3);
    exp_fcnt.push_back(16'd4);
    enable = 1'b1;
    for (int k = 0; k < 46; k++) begin
      @(negedge clk);
      if (k == 8) pattern_sel = 2'd2;
      if (k == 45) enable = 1'b0;
    end
    wait_idle("latch");

    // Enable dropped during the second line
    do_reset();
    pattern_sel = 2'd0;
    push_hramp_frame();
    exp_fcnt.push_back(16'd1);
    enable = 1'b1;
    for (int k = 0; k < 31; k++) begin
      @(negedge clk);
      if (k == 9) enable = 1'b0;
      if (k == 23) check("drop_busy_vblank", {31'd0, busy}, 32'd1);
      if (k == 24) begin
        check("drop_busy_idle", {31'd0, busy}, 32'd0);
        check("drop_fval_idle", {31'd0, fval}, 32'd0);
      end
    end
    check("drop_frame_cnt", {16'd0, frame_cnt}, 32'd1);
    check("drop_fdone_pending", exp_fcnt.size(), 32'd0);

    // Reset abort during HBLANK
    pattern_sel = 2'd0;
    push_line(12'h000, 12'h001, 12'h002, 12'h003);
    enable = 1'b1;
    for (int k = 0; k < 7; k++) @(negedge clk);
    check("pre_abort_fval", {31'd0, fval}, 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check("abort_pix",   {20'd0, pix_d}, 32'd0);
    check("abort_fval",  {31'd0, fval}, 32'd0);
    check("abort_lval",  {31'd0, lval}, 32'd0);
    check("abort_fdone", {31'd0, frame_done}, 32'd0);
    check("abort_fcnt",  {16'd0, frame_cnt}, 32'd0);
    check("abort_busy",  {31'd0, busy}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    push_hramp_frame();
    exp_fcnt.push_back(16'd1);
    reset_n = 1'b1;
    for (int k = 0; k < 31; k++) begin
      @(negedge clk);
      if (k == 0) check("restart_fval_k0", {31'd0, fval}, 32'd0);
      if (k == 1) check("restart_fval_k1", {31'd0, fval}, 32'd1);
      if (k == 9) enable = 1'b0;
    end
    wait_idle("abort");

    // Frame counter wrap with the frame-count pattern
    @(negedge clk);
    force dut.frame_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt_q;
    @(negedge clk);
    check("cnt_preset", {16'd0, frame_cnt}, 32'h0000FFFF);
    pattern_sel = 2'd3;
    push_line(12'hF5A, 12'hF5A, 12'hF5A, 12'hF5A);
    push_line(12'hF5A, 12'hF5A, 12'hF5A, 12'hF5A);
    push_line(12'hF5A, 12'hF5A, 12'hF5A, 12'hF5A);
    push_line(12'h05A, 12'h05A, 12'h05A, 12'h05A);
    push_line(12'h05A, 12'h05A, 12'h05A, 12'h05A);
    push_line(12'h05A, 12'h05A, 12'h05A, 12'h05A);
    exp_fcnt.push_back(16'h0000);
    exp_fcnt.push_back(16'h0001);
    enable = 1'b1;
    for (int k = 0; k < 46; k++) begin
      @(negedge clk);
      if (k == 45) enable = 1'b0;
    end
    wait_idle("wrap");

    @(negedge clk);
    check("pix_pending", exp_pix.size(), 32'd0);
    check("fdone_pending", exp_fcnt.size(), 32'd0);
    mon_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
